// File: rtl/shift_rows_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : shift_rows_pipe
//  Purpose  : Pipelined AES/Rijndael ShiftRows / InvShiftRows stage for
//             block widths NB = 4, 6 or 8 columns. It moves data through an
//             elastic valid/ready register chain of STAGES stages and carries
//             a sideband tag with each state.
//  Ports    : clk, rst (synchronous, active-high)
//             in_valid/in_ready, in_state[32*NB], in_inv, in_tag[TAG_W]
//             out_valid/out_ready, out_state[32*NB], out_inv, out_tag[TAG_W]
//             in_bypass / out_bypass exist only with SHIFT_ROWS_PIPE_BYPASS_EN
//  Options  : `define SHIFT_ROWS_PIPE_BYPASS_EN adds the per-state bypass flag
//  Revision : 1.0 - initial release
// ============================================================================
module shift_rows_pipe #(
    parameter int NB     = 4,
    parameter int STAGES = 1,
    parameter int TAG_W  = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [32*NB-1:0]    in_state,
    input  logic                in_inv,
    input  logic [TAG_W-1:0]    in_tag,
`ifdef SHIFT_ROWS_PIPE_BYPASS_EN
    input  logic                in_bypass,
    output logic                out_bypass,
`endif
    output logic                out_valid,
    input  logic                out_ready,
    output logic [32*NB-1:0]    out_state,
    output logic                out_inv,
    output logic [TAG_W-1:0]    out_tag
);

    localparam int W = 32 * NB;

    // Parameter legality is enforced at elaboration time.
    generate
        if (!(NB == 4 || NB == 6 || NB == 8)) begin : g_bad_nb
            $error("shift_rows_pipe: NB must be 4, 6 or 8");
        end
        if (STAGES < 1 || STAGES > 4) begin : g_bad_stages
            $error("shift_rows_pipe: STAGES must be in 1..4");
        end
    endgenerate

    // Rijndael row offsets; the 256-bit block uses a wider spread on rows 2/3.
    function automatic int row_off(input int r);
        case (r)
            0:       row_off = 0;
            1:       row_off = 1;
            2:       row_off = (NB == 8) ? 3 : 2;
            default: row_off = (NB == 8) ? 4 : 3;
        endcase
    endfunction

    // ------------------------------------------------------------------
    // Combinational permutation. Byte k (row k%4, column k/4) sits at
    // bits [W-1-8k -: 8]. Each output byte gathers its source column;
    // the inverse gathers from the opposite rotation.
    // ------------------------------------------------------------------
    logic [W-1:0] w_perm;
    logic [W-1:0] w_stage_in;

    always_comb begin
        w_perm = '0;
        for (int c = 0; c < NB; c++) begin
            for (int r = 0; r < 4; r++) begin
                int src;
                if (in_inv) src = (c + NB - row_off(r)) % NB;
                else        src = (c + row_off(r)) % NB;
                w_perm[W-1-8*(4*c+r) -: 8] = in_state[W-1-8*(4*src+r) -: 8];
            end
        end
    end

`ifdef SHIFT_ROWS_PIPE_BYPASS_EN
    assign w_stage_in = in_bypass ? in_state : w_perm;
`else
    assign w_stage_in = w_perm;
`endif

    // ------------------------------------------------------------------
    // Elastic stage chain
    // ------------------------------------------------------------------
    logic [STAGES-1:0] r_valid;
    logic [W-1:0]      r_data [STAGES];
    logic              r_inv  [STAGES];
    logic [TAG_W-1:0]  r_tag  [STAGES];

    logic [STAGES-1:0] w_src_valid;
    logic [W-1:0]      w_src_data [STAGES];
    logic              w_src_inv  [STAGES];
    logic [TAG_W-1:0]  w_src_tag  [STAGES];
    logic [STAGES-1:0] w_accept;

`ifdef SHIFT_ROWS_PIPE_BYPASS_EN
    logic              r_byp     [STAGES];
    logic              w_src_byp [STAGES];
`endif

    // Stage 0 is fed from the port, every later stage from its predecessor.
    generate
        for (genvar s = 0; s < STAGES; s++) begin : g_src
            if (s == 0) begin : g_head
                assign w_src_valid[s] = in_valid;
                assign w_src_data[s]  = w_stage_in;
                assign w_src_inv[s]   = in_inv;
                assign w_src_tag[s]   = in_tag;
`ifdef SHIFT_ROWS_PIPE_BYPASS_EN
                assign w_src_byp[s]   = in_bypass;
`endif
            end else begin : g_chain
                assign w_src_valid[s] = r_valid[s-1];
                assign w_src_data[s]  = r_data[s-1];
                assign w_src_inv[s]   = r_inv[s-1];
                assign w_src_tag[s]   = r_tag[s-1];
`ifdef SHIFT_ROWS_PIPE_BYPASS_EN
                assign w_src_byp[s]   = r_byp[s-1];
`endif
            end
        end
    endgenerate

    // A stage may load when it or any stage downstream of it is empty, or
    // when the consumer takes the last stage. Written in closed form so the
    // ready chain has no combinational self-reference.
    always_comb begin
        w_accept = '0;
        for (int s = 0; s < STAGES; s++) begin
            w_accept[s] = out_ready;
            for (int j = s; j < STAGES; j++) begin
                if (!r_valid[j]) w_accept[s] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= '0;
            for (int s = 0; s < STAGES; s++) begin
                r_data[s] <= '0;
                r_inv[s]  <= 1'b0;
                r_tag[s]  <= '0;
`ifdef SHIFT_ROWS_PIPE_BYPASS_EN
                r_byp[s]  <= 1'b0;
`endif
            end
        end else begin
            for (int s = 0; s < STAGES; s++) begin
                if (w_accept[s]) begin
                    r_valid[s] <= w_src_valid[s];
                    // Payload only moves with a valid state; bubbles leave it.
                    if (w_src_valid[s]) begin
                        r_data[s] <= w_src_data[s];
                        r_inv[s]  <= w_src_inv[s];
                        r_tag[s]  <= w_src_tag[s];
`ifdef SHIFT_ROWS_PIPE_BYPASS_EN
                        r_byp[s]  <= w_src_byp[s];
`endif
                    end
                end
            end
        end
    end

    assign in_ready  = w_accept[0] & ~rst;
    assign out_valid = r_valid[STAGES-1];
    assign out_state = r_data[STAGES-1];
    assign out_inv   = r_inv[STAGES-1];
    assign out_tag   = r_tag[STAGES-1];
`ifdef SHIFT_ROWS_PIPE_BYPASS_EN
    assign out_bypass = r_byp[STAGES-1];
`endif

endmodule
`default_nettype wire

// File: tb/tb_shift_rows_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : tb_shift_rows_pipe
//  Purpose  : Self-checking bench for shift_rows_pipe. Main DUT: NB=4,
//             STAGES=3; a second DUT (NB=8, STAGES=1) covers the wide block.
//             Expected states come from a byte-array reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_shift_rows_pipe;

    localparam int S4 = 3;

    logic         clk = 1'b0;
    logic         rst = 1'b1;

    // NB=4 DUT
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [127:0] in_state = '0;
    logic         in_inv = 1'b0;
    logic [3:0]   in_tag = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [127:0] out_state;
    logic         out_inv;
    logic [3:0]   out_tag;
`ifdef SHIFT_ROWS_PIPE_BYPASS_EN
    logic         in_bypass = 1'b0;
    logic         out_bypass;
`endif

    // NB=8 DUT
    logic         w_valid = 1'b0;
    logic         w_ready;
    logic [255:0] w_state = '0;
    logic         w_out_valid;
    logic [255:0] w_out_state;
    logic         w_out_inv;
    logic [3:0]   w_out_tag;
`ifdef SHIFT_ROWS_PIPE_BYPASS_EN
    logic         w_out_bypass;
`endif

    always #5 clk = ~clk;

    shift_rows_pipe #(.NB(4), .STAGES(S4), .TAG_W(4)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_state(in_state),
        .in_inv(in_inv), .in_tag(in_tag),
`ifdef SHIFT_ROWS_PIPE_BYPASS_EN
        .in_bypass(in_bypass), .out_bypass(out_bypass),
`endif
        .out_valid(out_valid), .out_ready(out_ready), .out_state(out_state),
        .out_inv(out_inv), .out_tag(out_tag)
    );

    shift_rows_pipe #(.NB(8), .STAGES(1), .TAG_W(4)) dut8 (
        .clk(clk), .rst(rst),
        .in_valid(w_valid), .in_ready(w_ready), .in_state(w_state),
        .in_inv(1'b0), .in_tag(4'h0),
`ifdef SHIFT_ROWS_PIPE_BYPASS_EN
        .in_bypass(1'b0), .out_bypass(w_out_bypass),
`endif
        .out_valid(w_out_valid), .out_ready(1'b1), .out_state(w_out_state),
        .out_inv(w_out_inv), .out_tag(w_out_tag)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: rows/columns as a byte array, straight from the
    // definitions (forward gathers, inverse scatters).
    function automatic logic [255:0] ref_shift(input logic [255:0] s, input int nb, input logic inv);
        logic [7:0] b [32];
        logic [7:0] o [32];
        int         off [4];
        logic [255:0] res;
        off[0] = 0; off[1] = 1;
        off[2] = (nb == 8) ? 3 : 2;
        off[3] = (nb == 8) ? 4 : 3;
        for (int k = 0; k < 32; k++) begin b[k] = 8'h00; o[k] = 8'h00; end
        for (int k = 0; k < 4*nb; k++) b[k] = s[8*(4*nb-k)-1 -: 8];
        for (int c = 0; c < nb; c++)
            for (int r = 0; r < 4; r++)
                if (!inv) o[4*c+r] = b[4*((c+off[r])%nb)+r];
                else      o[4*((c+off[r])%nb)+r] = b[4*c+r];
        res = '0;
        for (int k = 0; k < 4*nb; k++) res[8*(4*nb-k)-1 -: 8] = o[k];
        return res;
    endfunction

    typedef struct {
        logic [127:0] st;
        logic         inv;
        logic [3:0]   tag;
        logic         byp;
    } item_t;

    item_t        sb[$];
    logic         last_in_fire;
    logic         last_out_fire;
    logic [127:0] last_out_state;
    logic         stall_prev = 1'b0;
    logic [127:0] prev_state;
    logic [3:0]   prev_tag;
    logic         prev_inv;
    int           n_out = 0;

    // One clock cycle on the NB=4 DUT: drive at negedge, observe 1 ns later.
    task automatic step(input logic v, input logic rdy, input logic [127:0] st,
                        input logic inv, input logic [3:0] tag, input logic byp);
        item_t e;
        @(negedge clk);
        in_valid = v; out_ready = rdy; in_state = st; in_inv = inv; in_tag = tag;
`ifdef SHIFT_ROWS_PIPE_BYPASS_EN
        in_bypass = byp;
`endif
        #1;
        if (stall_prev) begin
            check("stall_valid", out_valid, 1'b1);
            check("stall_state", out_state, prev_state);
            check("stall_tag", out_tag, prev_tag);
            check("stall_inv", out_inv, prev_inv);
        end
        // Pipeline only refuses when every stage holds a state and is blocked.
        check("in_ready", in_ready, (sb.size() < S4) || rdy);
        last_out_fire = out_valid && rdy;
        if (last_out_fire) begin
            last_out_state = out_state;
            n_out++;
            if (sb.size() == 0) begin
                check("spurious_out", 1'b1, 1'b0);
            end else begin
                e = sb.pop_front();
                check("out_state", out_state,
                      e.byp ? {128'h0, e.st} : ref_shift({128'h0, e.st}, 4, e.inv));
                check("out_tag", out_tag, e.tag);
                check("out_inv", out_inv, e.inv);
`ifdef SHIFT_ROWS_PIPE_BYPASS_EN
                check("out_bypass", out_bypass, e.byp);
`endif
            end
        end
        last_in_fire = v && in_ready;
        if (last_in_fire) begin
            e.st = st; e.inv = inv; e.tag = tag; e.byp = byp;
            sb.push_back(e);
        end
        stall_prev = out_valid && !rdy;
        prev_state = out_state;
        prev_tag   = out_tag;
        prev_inv   = out_inv;
    endtask

    // Single state into an idle pipe: checks acceptance, latency and value.
    task automatic send_timed(input string name, input logic [127:0] st, input logic inv,
                              input logic byp, input logic [127:0] exp);
        int lat;
        step(1'b1, 1'b1, st, inv, 4'h5, byp);
        check({name, "_acc"}, last_in_fire, 1'b1);
        lat = 0;
        for (int i = 1; i <= 20 && lat == 0; i++) begin
            step(1'b0, 1'b1, '0, 1'b0, 4'h0, 1'b0);
            if (last_out_fire) lat = i;
        end
        check({name, "_latency"}, lat, S4);
        check({name, "_state"}, last_out_state, exp);
    endtask

    logic [255:0] seq32;
    int           sent;
    int           out_before;

    initial begin
        // ---------------- reset state ----------------
        repeat (3) @(negedge clk);
        #1;
        check("rst_in_ready", in_ready, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_state", out_state, '0);
        check("rst_out_tag", out_tag, '0);
        check("rst_out_inv", out_inv, 1'b0);
        check("rst_in_ready_after", in_ready, 1'b1);

        // ---------------- directed vectors ----------------
        send_timed("fips", 128'hd42711aee0bf98f1b8b45de51e415230, 1'b0, 1'b0,
                   128'hd4bf5d30e0b452aeb84111f11e2798e5);
        send_timed("fwd", 128'h000102030405060708090a0b0c0d0e0f, 1'b0, 1'b0,
                   128'h00050a0f04090e03080d02070c01060b);
        send_timed("inv", 128'h00050a0f04090e03080d02070c01060b, 1'b1, 1'b0,
                   128'h000102030405060708090a0b0c0d0e0f);
`ifdef SHIFT_ROWS_PIPE_BYPASS_EN
        send_timed("bypass", 128'h000102030405060708090a0b0c0d0e0f, 1'b1, 1'b1,
                   128'h000102030405060708090a0b0c0d0e0f);
`endif

        // ---------------- NB=8 wide block ----------------
        for (int k = 0; k < 32; k++) seq32[255-8*k -: 8] = k[7:0];
        @(negedge clk);
        w_valid = 1'b1; w_state = seq32;
        #1;
        check("nb8_ready", w_ready, 1'b1);
        @(negedge clk);
        w_valid = 1'b0;
        #1;
        check("nb8_valid", w_out_valid, 1'b1);
        check("nb8_col0", w_out_state[255:224], 32'h00050e13);
        check("nb8_col7", w_out_state[31:0], 32'h1c010a0f);
        check("nb8_state", w_out_state, ref_shift(seq32, 8, 1'b0));

        // ---------------- back-pressure: 6 states, stall cycles 4-8 -------
        sent = 0;
        out_before = n_out;
        for (int cyc = 0; cyc < 30; cyc++) begin
            step(sent < 6, !(cyc >= 4 && cyc <= 8),
                 {$urandom, $urandom, $urandom, $urandom}, 1'(cyc & 1),
                 4'(sent + 1), 1'b0);
            if (last_in_fire) sent++;
        end
        check("bp_sent", sent, 6);
        check("bp_received", n_out - out_before, 6);
        check("bp_drained", sb.size(), 0);

        // ---------------- reset mid-stream ----------------
        step(1'b1, 1'b0, 128'h11112222333344445555666677778888, 1'b0, 4'h9, 1'b0);
        step(1'b1, 1'b0, 128'h99990000aaaabbbbccccddddeeeeffff, 1'b1, 4'ha, 1'b0);
        check("mid_inflight", sb.size(), 2);
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        #1;
        check("mid_rst_ready", in_ready, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("mid_out_valid", out_valid, 1'b0);
        check("mid_out_state", out_state, '0);
        check("mid_out_tag", out_tag, '0);
        sb.delete();
        stall_prev = 1'b0;
        send_timed("post_rst", 128'h000102030405060708090a0b0c0d0e0f, 1'b0, 1'b0,
                   128'h00050a0f04090e03080d02070c01060b);

        // ---------------- randomized traffic ----------------
        for (int cyc = 0; cyc < 400; cyc++) begin
            step($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                 {$urandom, $urandom, $urandom, $urandom}, 1'($urandom),
                 4'($urandom),
`ifdef SHIFT_ROWS_PIPE_BYPASS_EN
                 1'($urandom)
`else
                 1'b0
`endif
                 );
        end
        for (int i = 0; i < 40 && sb.size() != 0; i++)
            step(1'b0, 1'b1, '0, 1'b0, 4'h0, 1'b0);
        check("rand_drained", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/shift_rows_pipe.md
Name: shift_rows_pipe

Overview:
- Parametrised, pipelined successor of the combinational AES ShiftRows stage.
- Supports Rijndael block widths NB = 4, 6 or 8 columns.
- Selects forward (ShiftRows) or inverse (InvShiftRows) per transfer, carries a user tag alongside the state, and moves data through an elastic valid/ready register pipeline of configurable depth.
- Sits between SubBytes and MixColumns in the round datapath; the inverse mode is used by the decrypt round.

Parameters:
- NB, 4, number of 32-bit state columns; legal values 4, 6, 8; any other value fails elaboration.
- STAGES, 1, number of register stages; legal 1..4.
- TAG_W, 4, width of the sideband tag carried with each state (round index, stream id).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  upstream presents a state.
- in_ready  output  1  block can accept this cycle.
- in_state  input  32*NB  state, column-major; byte 0 (row 0, col 0) at bits [32*NB-1 -: 8]; byte k = row (k mod 4), column (k div 4).
- in_inv  input  1  0 = ShiftRows, 1 = InvShiftRows.
- in_tag  input  TAG_W  sideband, passed through unchanged.
- out_valid  output  1  transformed state available.
- out_ready  input  1  downstream accepts.
- out_state  output  32*NB  transformed state.
- out_inv  output  1  mode used for this state.
- out_tag  output  TAG_W  tag of this state.

Behaviour:
- Row offsets C(r):
  - NB = 4 or 6: C = 0, 1, 2, 3.
  - NB = 8: C = 0, 1, 3, 4.
- Forward mapping: out[r][c] = in[r][(c + C(r)) mod NB].
- Inverse mapping: out[r][(c + C(r)) mod NB] = in[r][c].
- Permutation is combinational on in_state, selected by in_inv, and is captured into stage 1 on an accepted transfer.
- Stages 2..STAGES are plain elastic copies.
- Each stage holds a valid bit plus data/inv/tag.
- A stage loads when (its valid = 0) or (the next stage, or out_ready for the last stage, accepts).
- in_ready = (stage-1 valid = 0) OR stage 1 advances this cycle. in_ready is combinational from out_ready through the stage chain; no skid buffer is used.
- Transfers:
  - Input transfer occurs when in_valid & in_ready.
  - Output transfer occurs when out_valid & out_ready.
  - out_valid, out_state, out_inv and out_tag are driven from the last stage register.
- Latency: STAGES cycles from the accepted input to out_valid, with no stalls.
- Throughput: one state per cycle when out_ready is held high.
- Stall: when out_ready = 0 with the pipeline full, all stages hold, outputs stay stable, and in_ready = 0.
- Bubbles: an empty stage is filled while downstream is stalled, so a gap between valid states collapses.
- Simultaneous input transfer and output transfer on a full pipeline: both occur; occupancy is unchanged.
- in_state, in_inv and in_tag are ignored when in_valid = 0.
- Reset values: all stage valid bits 0, data/inv/tag 0; out_valid = 0, out_state = 0, out_inv = 0, out_tag = 0; in_ready = 1 in the first cycle after reset deasserts.
- Reset asserted mid-operation discards all in-flight states at that edge; no partial output is produced.
- While rst is high, in_ready = 0.

Optional Feature:
- Macro: SHIFT_ROWS_PIPE_BYPASS_EN.
- Defined:
  - Adds input port in_bypass (1 bit).
  - When in_bypass = 1 on an accepted transfer, in_state is registered unpermuted; in_inv is still carried to out_inv.
  - Adds output port out_bypass, which reports the flag for that state.
- Undefined: neither port exists and every state is permuted.

Test Plan:
- NB=4, STAGES=1, forward: in_state = 0xd42711aee0bf98f1b8b45de51e415230 (FIPS-197 round 1) -> one cycle later out_state = 0xd4bf5d30e0b452aeb84111f11e2798e5, out_valid = 1.
- NB=4, forward then inverse:
  - in_state = 0x000102030405060708090a0b0c0d0e0f, in_inv = 0 -> out_state = 0x00050a0f04090e03080d02070c01060b.
  - Feed that output back with in_inv = 1 -> out_state = 0x000102...0f.
- NB=8, forward: in_state = bytes 0x00..0x1f -> out column 0 = 00 05 0e 13; out column 7 = 1c 01 0a 0f.
- STAGES=3, back-pressure:
  - Stream 6 states with tags 1..6; hold out_ready = 0 for cycles 4-8.
  - Expected: in_ready falls once 3 states are held; outputs stay stable during the stall; all 6 appear in order with matching tags; no drops or duplicates.
- Reset mid-stream: assert rst with 2 states in flight -> next cycle out_valid = 0 and out_state = 0; a new state accepted after reset exits after STAGES cycles.
- With SHIFT_ROWS_PIPE_BYPASS_EN: in_bypass = 1, in_state = 0x000102...0f -> out_state identical to input, out_bypass = 1.
